// File: rtl/aes_pkg.sv
// Shared AES definitions: widths, state type, SubBytes FSM encoding and S-box tables.
package aes_pkg;

    localparam int AES_BLOCK_W   = 128;
    localparam int AES_BYTE_W    = 8;
    localparam int AES_NUM_BYTES = AES_BLOCK_W / AES_BYTE_W;

    // Byte i of a state occupies bits [8i:8i+7]; byte 0 is the leftmost byte.
    typedef logic [0:AES_BLOCK_W-1] aes_state_t;
    typedef logic [AES_BYTE_W-1:0]  aes_byte_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sb_fsm_t;

    // Forward S-box, entry 0x00 in the most significant byte.
    // Entry k lives at bits [{~k,3'b000} +: 8].
    localparam logic [2047:0] SBOX_FWD = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Inverse table is derived from the forward one so the two can never disagree.
    function automatic logic [2047:0] invert_sbox(input logic [2047:0] fwd);
        logic [2047:0] inv_tab;
        logic [7:0]    k8;
        logic [7:0]    v;
        inv_tab = '0;
        for (int k = 0; k < 256; k++) begin
            k8 = 8'(k);
            v  = fwd[{~k8, 3'b000} +: 8];
            inv_tab[{~v, 3'b000} +: 8] = k8;
        end
        return inv_tab;
    endfunction

    localparam logic [2047:0] SBOX_INV = invert_sbox(SBOX_FWD);

endpackage

// File: rtl/aes_sbox.sv
// Single combinational AES S-box lookup; INV selects the decryption table.
module aes_sbox
    import aes_pkg::*;
#(
    parameter int INV = 0
) (
    input  aes_byte_t byte_val,
    output aes_byte_t sub_val
);

    localparam logic [2047:0] TABLE = (INV != 0) ? SBOX_INV : SBOX_FWD;

    // Pure table lookup, byte value is the index.
    always_comb begin
        sub_val = TABLE[{~byte_val, 3'b000} +: 8];
    end

endmodule

// File: rtl/sub_bytes_seq.sv
// Iterative SubBytes: substitutes BYTES_PER_CYCLE bytes per clock through shared S-boxes
// and holds the finished state until the consumer takes it.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both high.
// in_ready is high in IDLE, and in DONE follows out_ready so a new state can load on
// the same edge the result leaves. out_valid stays high with sb_state frozen until
// out_ready; valid never depends on ready on the output side.
module sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int BYTES_PER_CYCLE = 4,
    parameter int INV             = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  aes_state_t in_state,
    output logic       out_valid,
    input  logic       out_ready,
    output aes_state_t sb_state,
    output logic       busy,
    output sb_fsm_t    fsm_state
);

    localparam int N        = AES_NUM_BYTES / BYTES_PER_CYCLE;
    localparam int GRP_W    = AES_BYTE_W * BYTES_PER_CYCLE;
    localparam int CNT_W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    sb_fsm_t          state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    aes_state_t       work, work_nxt;

    // Group view of the work register, the group selected by cnt, and its substitution.
    logic [0:GRP_W-1] grp [N];
    logic [0:GRP_W-1] grp_sel;
    logic [0:GRP_W-1] grp_sub;
    aes_state_t       work_run;

    for (genvar g = 0; g < N; g++) begin : g_group
        assign grp[g] = work[GRP_W*g +: GRP_W];
        // Only the active group is replaced; the rest pass through unchanged.
        assign work_run[GRP_W*g +: GRP_W] = (cnt == CNT_W'(g)) ? grp_sub : grp[g];
    end

    if (N == 1) begin : g_sel_single
        assign grp_sel = grp[0];
    end else begin : g_sel_mux
        assign grp_sel = grp[cnt];
    end

    for (genvar l = 0; l < BYTES_PER_CYCLE; l++) begin : g_lane
        aes_sbox #(.INV(INV)) u_sbox (
            .byte_val (grp_sel[AES_BYTE_W*l +: AES_BYTE_W]),
            .sub_val  (grp_sub[AES_BYTE_W*l +: AES_BYTE_W])
        );
    end

    // State register, group counter and work register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            work  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            work  <= work_nxt;
        end
    end

    // Next-state, counter/work updates and handshake outputs.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        work_nxt  = work;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    work_nxt  = in_state;
                    cnt_nxt   = '0;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                busy     = 1'b1;
                work_nxt = work_run;
                if (cnt == CNT_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_DONE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        work_nxt  = in_state;
                        cnt_nxt   = '0;
                        state_nxt = ST_RUN;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign sb_state  = work;
    assign fsm_state = state;

endmodule
